// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared 720p timing defaults and signal bundle type for video_sig_gen
package video_pkg;

  localparam int DEF_ACTIVE_H = 1280;
  localparam int DEF_FP_H     = 110;
  localparam int DEF_SYNC_H   = 40;
  localparam int DEF_BP_H     = 220;

  localparam int DEF_ACTIVE_V = 720;
  localparam int DEF_FP_V     = 5;
  localparam int DEF_SYNC_V   = 5;
  localparam int DEF_BP_V     = 20;

  localparam int DEF_TOTAL_H = DEF_ACTIVE_H + DEF_FP_H + DEF_SYNC_H + DEF_BP_H;
  localparam int DEF_TOTAL_V = DEF_ACTIVE_V + DEF_FP_V + DEF_SYNC_V + DEF_BP_V;

  // Timing strobes that travel together through the renderer-alignment delay line.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
  } vid_sig_t;

endpackage

// File: rtl/sig_pipe.sv
// rtl/sig_pipe.sv - fixed-depth shift-register delay line with async active-low reset
module sig_pipe #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  generate
    if (DEPTH == 0) begin : g_bypass
      // Zero depth is a pure wire so delayed outputs track the source in the same cycle.
      assign data_out = data_in;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];

      // Shift one stage per clock; only reset clears the contents.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
          end
        end else begin
          stage_q[0] <= data_in;
          for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
          end
        end
      end

      assign data_out = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/video_sig_gen.sv
// rtl/video_sig_gen.sv - raster counters, sync/active strobes, frame pulse and renderer-aligned copies
module video_sig_gen
  import video_pkg::*;
#(
  parameter int ACTIVE_H       = DEF_ACTIVE_H,
  parameter int FP_H           = DEF_FP_H,
  parameter int SYNC_H         = DEF_SYNC_H,
  parameter int BP_H           = DEF_BP_H,
  parameter int ACTIVE_V       = DEF_ACTIVE_V,
  parameter int FP_V           = DEF_FP_V,
  parameter int SYNC_V         = DEF_SYNC_V,
  parameter int BP_V           = DEF_BP_V,
  parameter int RENDER_LATENCY = 4
) (
  input  logic                                             clk_pixel_in,
  input  logic                                             rst_n_in,
  output logic [$clog2(ACTIVE_H+FP_H+SYNC_H+BP_H)-1:0]     hcount_out,
  output logic [$clog2(ACTIVE_V+FP_V+SYNC_V+BP_V)-1:0]     vcount_out,
  output logic                                             hsync_out,
  output logic                                             vsync_out,
  output logic                                             active_draw_out,
  output logic                                             hsync_d_out,
  output logic                                             vsync_d_out,
  output logic                                             active_d_out,
  output logic                                             new_frame_out,
  output logic [5:0]                                       frame_count_out
);

  localparam int TOTAL_H = ACTIVE_H + FP_H + SYNC_H + BP_H;
  localparam int TOTAL_V = ACTIVE_V + FP_V + SYNC_V + BP_V;
  localparam int HW      = $clog2(TOTAL_H);
  localparam int VW      = $clog2(TOTAL_V);

  // Inclusive bounds avoid overflowing the counter width when a window ends at the last count.
  localparam logic [HW-1:0] H_LAST       = HW'(TOTAL_H - 1);
  localparam logic [HW-1:0] H_ACT_LAST   = HW'(ACTIVE_H - 1);
  localparam logic [HW-1:0] H_SYNC_FIRST = HW'(ACTIVE_H + FP_H);
  localparam logic [HW-1:0] H_SYNC_LAST  = HW'(ACTIVE_H + FP_H + SYNC_H - 1);
  localparam logic [HW-1:0] H_FRAME_MARK = HW'(ACTIVE_H);

  localparam logic [VW-1:0] V_LAST       = VW'(TOTAL_V - 1);
  localparam logic [VW-1:0] V_ACT_LAST   = VW'(ACTIVE_V - 1);
  localparam logic [VW-1:0] V_SYNC_FIRST = VW'(ACTIVE_V + FP_V);
  localparam logic [VW-1:0] V_SYNC_LAST  = VW'(ACTIVE_V + FP_V + SYNC_V - 1);
  localparam logic [VW-1:0] V_FRAME_MARK = VW'(ACTIVE_V);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [5:0]    frame_q;
  logic          h_wrap;
  logic          new_frame;
  vid_sig_t      sig_now;
  vid_sig_t      sig_dly;

  // Next raster position: horizontal free-runs, vertical steps only on horizontal wrap.
  always_comb begin
    h_wrap = (h_q == H_LAST);
    h_d    = h_wrap ? '0 : h_q + 1'b1;
    v_d    = v_q;
    if (h_wrap) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
  end

  // Raster position registers.
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Strobes decoded straight from the registered counters so they add no latency.
  always_comb begin
    sig_now.active = (h_q <= H_ACT_LAST) && (v_q <= V_ACT_LAST);
    sig_now.hsync  = (h_q >= H_SYNC_FIRST) && (h_q <= H_SYNC_LAST);
    sig_now.vsync  = (v_q >= V_SYNC_FIRST) && (v_q <= V_SYNC_LAST);
    new_frame      = (h_q == H_FRAME_MARK) && (v_q == V_FRAME_MARK);
  end

  // Frame counter steps on the edge that ends the new-frame cycle; wraps naturally at 64.
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      frame_q <= '0;
    end else if (new_frame) begin
      frame_q <= frame_q + 6'd1;
    end
  end

  sig_pipe #(
    .WIDTH ($bits(vid_sig_t)),
    .DEPTH (RENDER_LATENCY)
  ) u_sig_pipe (
    .clk      (clk_pixel_in),
    .rst_n    (rst_n_in),
    .data_in  (sig_now),
    .data_out (sig_dly)
  );

  assign hcount_out      = h_q;
  assign vcount_out      = v_q;
  assign hsync_out       = sig_now.hsync;
  assign vsync_out       = sig_now.vsync;
  assign active_draw_out = sig_now.active;
  assign new_frame_out   = new_frame;
  assign frame_count_out = frame_q;
  assign hsync_d_out     = sig_dly.hsync;
  assign vsync_d_out     = sig_dly.vsync;
  assign active_d_out    = sig_dly.active;

endmodule
